// File: rtl/index_register_bank_if.sv
// Bus bundle for index_register_bank: operation request in, register state and status out.
// The master side issues ops; the slave side is the register bank.
interface index_register_bank_if #(
  parameter int WIDTH = 8,
  parameter int NREG  = 2
);
  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [2:0]            op;
  logic [SW-1:0]         sel_dst;
  logic [SW-1:0]         sel_src;
  logic [WIDTH-1:0]      IN_DATA;
  logic [WIDTH-1:0]      OUT_SEL;
  logic [NREG*WIDTH-1:0] OUT_ALL;
  logic                  flag_N;
  logic                  flag_Z;
  logic                  flag_W;
  logic                  upd_valid;
  logic                  err;

  modport master (
    output op, sel_dst, sel_src, IN_DATA,
    input  OUT_SEL, OUT_ALL, flag_N, flag_Z, flag_W, upd_valid, err
  );

  modport slave (
    input  op, sel_dst, sel_src, IN_DATA,
    output OUT_SEL, OUT_ALL, flag_N, flag_Z, flag_W, upd_valid, err
  );
endinterface

// File: rtl/index_register_bank.sv
// Bank of NREG index registers with load/inc/dec/transfer/clear ops, status flags and
// accept/reject pulses. All state changes on the falling edge of FSM_Signal.
module index_register_bank #(
  parameter int              WIDTH     = 8,
  parameter int              NREG      = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                FSM_Signal,
  input  logic                reset_IDX,
  index_register_bank_if.slave bus
);
  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_LOAD     = 3'd1,
    OP_INC      = 3'd2,
    OP_DEC      = 3'd3,
    OP_TRANSFER = 3'd4,
    OP_CLEAR    = 3'd5
  } op_e;

  logic [WIDTH-1:0] regs [NREG];
  logic             flag_n_q;
  logic             flag_z_q;
  logic             flag_w_q;
  logic             upd_valid_q;
  logic             err_q;

  logic [WIDTH-1:0] old_dst;
  logic [WIDTH-1:0] src_val;
  logic             dst_ok;
  logic             src_ok;
  logic [WIDTH-1:0] new_val;
  logic             wrap;
  logic             write_op;
  logic             illegal;
  logic             accept;
  logic             reject;

  // Selectors are decoded against the real register count so that out-of-range
  // indices naturally read as zero and flag the op for rejection.
  always_comb begin
    old_dst = '0;
    src_val = '0;
    dst_ok  = 1'b0;
    src_ok  = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.sel_dst == SW'(i)) begin
        old_dst = regs[i];
        dst_ok  = 1'b1;
      end
      if (bus.sel_src == SW'(i)) begin
        src_val = regs[i];
        src_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    new_val  = old_dst;
    wrap     = 1'b0;
    write_op = 1'b0;
    illegal  = 1'b0;
    case (bus.op)
      OP_NOP:      ;
      OP_LOAD:     begin new_val = bus.IN_DATA;       write_op = 1'b1; end
      OP_INC:      begin new_val = old_dst + 1'b1;    wrap = &old_dst;  write_op = 1'b1; end
      OP_DEC:      begin new_val = old_dst - 1'b1;    wrap = ~|old_dst; write_op = 1'b1; end
      OP_TRANSFER: begin new_val = src_val;           write_op = 1'b1; end
      OP_CLEAR:    begin new_val = '0;                write_op = 1'b1; end
      default:     illegal = 1'b1;
    endcase
    accept = write_op && dst_ok && ((bus.op != OP_TRANSFER) || src_ok);
    reject = illegal || (write_op && !accept);
  end

  // Reset wins over any op in the same cycle; rejected ops and NOPs only touch the pulses.
  always_ff @(negedge FSM_Signal) begin
    if (reset_IDX) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RESET_VAL;
      flag_n_q    <= RESET_VAL[WIDTH-1];
      flag_z_q    <= (RESET_VAL == '0);
      flag_w_q    <= 1'b0;
      upd_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      upd_valid_q <= accept;
      err_q       <= reject;
      if (accept) begin
        for (int i = 0; i < NREG; i++) begin
          if (bus.sel_dst == SW'(i)) regs[i] <= new_val;
        end
        flag_n_q <= new_val[WIDTH-1];
        flag_z_q <= (new_val == '0);
        flag_w_q <= wrap;
      end
    end
  end

  always_comb begin
    bus.OUT_ALL = '0;
    for (int i = 0; i < NREG; i++) bus.OUT_ALL[i*WIDTH +: WIDTH] = regs[i];
  end

  assign bus.OUT_SEL   = src_val;
  assign bus.flag_N    = flag_n_q;
  assign bus.flag_Z    = flag_z_q;
  assign bus.flag_W    = flag_w_q;
  assign bus.upd_valid = upd_valid_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_index_register_bank.sv
// Directed bench for index_register_bank: a default 2-register bank and a 3-register
// bank with a non-zero reset value, driven as a linear sequence of ops.
module tb_index_register_bank;
  logic FSM_Signal = 1'b0;
  logic reset_IDX;
  int   passCount  = 0;
  int   checkCount = 0;

  index_register_bank_if #(.WIDTH(8), .NREG(2)) bus2 ();
  index_register_bank_if #(.WIDTH(8), .NREG(3)) bus3 ();

  index_register_bank #(.WIDTH(8), .NREG(2), .RESET_VAL(8'h00)) dut (
    .FSM_Signal (FSM_Signal),
    .reset_IDX  (reset_IDX),
    .bus        (bus2)
  );

  index_register_bank #(.WIDTH(8), .NREG(3), .RESET_VAL(8'h81)) dut3 (
    .FSM_Signal (FSM_Signal),
    .reset_IDX  (reset_IDX),
    .bus        (bus3)
  );

  always #5 FSM_Signal = ~FSM_Signal;

  // Drive one op into the chosen bank (2 or 3) while the other idles, then sample
  // just after the falling edge that consumes it.
  task automatic applyStimulus(input int unit, input logic [2:0] op, input logic [2:0] dst,
                               input logic [2:0] src, input logic [7:0] data);
    @(posedge FSM_Signal);
    bus2.op = 3'd0; bus2.sel_dst = 1'b0; bus2.sel_src = 1'b0; bus2.IN_DATA = 8'h00;
    bus3.op = 3'd0; bus3.sel_dst = 2'd0; bus3.sel_src = 2'd0; bus3.IN_DATA = 8'h00;
    if (unit == 3) begin
      bus3.op = op; bus3.sel_dst = dst[1:0]; bus3.sel_src = src[1:0]; bus3.IN_DATA = data;
    end else begin
      bus2.op = op; bus2.sel_dst = dst[0]; bus2.sel_src = src[0]; bus2.IN_DATA = data;
    end
    @(negedge FSM_Signal);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  initial begin
    reset_IDX = 1'b1;
    bus2.op = 3'd0; bus2.sel_dst = 1'b0; bus2.sel_src = 1'b0; bus2.IN_DATA = 8'h00;
    bus3.op = 3'd0; bus3.sel_dst = 2'd0; bus3.sel_src = 2'd0; bus3.IN_DATA = 8'h00;
    repeat (2) @(negedge FSM_Signal);
    #1;
    checkOutput("rst_all",    32'(bus2.OUT_ALL),   32'h0000);
    checkOutput("rst_N",      32'(bus2.flag_N),    32'd0);
    checkOutput("rst_Z",      32'(bus2.flag_Z),    32'd1);
    checkOutput("rst_W",      32'(bus2.flag_W),    32'd0);
    checkOutput("rst_upd",    32'(bus2.upd_valid), 32'd0);
    checkOutput("rst_err",    32'(bus2.err),       32'd0);
    checkOutput("rst3_all",   32'(bus3.OUT_ALL),   32'h818181);
    checkOutput("rst3_N",     32'(bus3.flag_N),    32'd1);
    checkOutput("rst3_Z",     32'(bus3.flag_Z),    32'd0);
    reset_IDX = 1'b0;

    applyStimulus(2, 3'd1, 3'd1, 3'd0, 8'h7F);
    checkOutput("load1_all",  32'(bus2.OUT_ALL),   32'h7F00);
    checkOutput("load1_upd",  32'(bus2.upd_valid), 32'd1);
    checkOutput("load1_N",    32'(bus2.flag_N),    32'd0);
    checkOutput("load1_Z",    32'(bus2.flag_Z),    32'd0);

    applyStimulus(2, 3'd2, 3'd1, 3'd0, 8'h00);
    checkOutput("inc1_all",   32'(bus2.OUT_ALL),   32'h8000);
    checkOutput("inc1_N",     32'(bus2.flag_N),    32'd1);
    checkOutput("inc1_Z",     32'(bus2.flag_Z),    32'd0);
    checkOutput("inc1_W",     32'(bus2.flag_W),    32'd0);
    checkOutput("inc1_upd",   32'(bus2.upd_valid), 32'd1);

    applyStimulus(2, 3'd0, 3'd0, 3'd1, 8'h00);
    checkOutput("nop_upd",    32'(bus2.upd_valid), 32'd0);
    checkOutput("nop_N",      32'(bus2.flag_N),    32'd1);
    checkOutput("nop_all",    32'(bus2.OUT_ALL),   32'h8000);
    checkOutput("nop_sel1",   32'(bus2.OUT_SEL),   32'h80);

    applyStimulus(2, 3'd1, 3'd0, 3'd0, 8'hFF);
    checkOutput("load0_all",  32'(bus2.OUT_ALL),   32'h80FF);
    applyStimulus(2, 3'd2, 3'd0, 3'd0, 8'h00);
    checkOutput("incwrap_all",32'(bus2.OUT_ALL),   32'h8000);
    checkOutput("incwrap_Z",  32'(bus2.flag_Z),    32'd1);
    checkOutput("incwrap_W",  32'(bus2.flag_W),    32'd1);
    checkOutput("incwrap_N",  32'(bus2.flag_N),    32'd0);
    applyStimulus(2, 3'd3, 3'd0, 3'd0, 8'h00);
    checkOutput("decwrap_all",32'(bus2.OUT_ALL),   32'h80FF);
    checkOutput("decwrap_W",  32'(bus2.flag_W),    32'd1);
    checkOutput("decwrap_N",  32'(bus2.flag_N),    32'd1);
    checkOutput("decwrap_Z",  32'(bus2.flag_Z),    32'd0);

    applyStimulus(2, 3'd1, 3'd0, 3'd0, 8'h05);
    checkOutput("load05_all", 32'(bus2.OUT_ALL),   32'h8005);
    checkOutput("load05_W",   32'(bus2.flag_W),    32'd0);
    applyStimulus(2, 3'd5, 3'd1, 3'd0, 8'h00);
    checkOutput("clr1_all",   32'(bus2.OUT_ALL),   32'h0005);
    checkOutput("clr1_Z",     32'(bus2.flag_Z),    32'd1);
    applyStimulus(2, 3'd3, 3'd1, 3'd0, 8'h00);
    checkOutput("dec1_all",   32'(bus2.OUT_ALL),   32'hFF05);
    checkOutput("dec1_W",     32'(bus2.flag_W),    32'd1);
    applyStimulus(2, 3'd4, 3'd1, 3'd0, 8'h00);
    checkOutput("xfer_all",   32'(bus2.OUT_ALL),   32'h0505);
    checkOutput("xfer_W",     32'(bus2.flag_W),    32'd0);
    checkOutput("xfer_N",     32'(bus2.flag_N),    32'd0);
    checkOutput("xfer_upd",   32'(bus2.upd_valid), 32'd1);
    checkOutput("xfer_sel0",  32'(bus2.OUT_SEL),   32'h05);
    applyStimulus(2, 3'd4, 3'd1, 3'd1, 8'h00);
    checkOutput("xself_all",  32'(bus2.OUT_ALL),   32'h0505);
    checkOutput("xself_upd",  32'(bus2.upd_valid), 32'd1);

    applyStimulus(2, 3'd6, 3'd0, 3'd0, 8'hAA);
    checkOutput("op6_err",    32'(bus2.err),       32'd1);
    checkOutput("op6_upd",    32'(bus2.upd_valid), 32'd0);
    checkOutput("op6_all",    32'(bus2.OUT_ALL),   32'h0505);
    applyStimulus(2, 3'd7, 3'd1, 3'd0, 8'hAA);
    checkOutput("op7_err",    32'(bus2.err),       32'd1);
    checkOutput("op7_all",    32'(bus2.OUT_ALL),   32'h0505);
    checkOutput("op7_flags",  32'({bus2.flag_N, bus2.flag_Z, bus2.flag_W}), 32'd0);
    applyStimulus(2, 3'd0, 3'd0, 3'd0, 8'h00);
    checkOutput("op7_clr",    32'(bus2.err),       32'd0);

    applyStimulus(2, 3'd1, 3'd0, 3'd0, 8'h00);
    applyStimulus(2, 3'd2, 3'd0, 3'd0, 8'h00);
    applyStimulus(2, 3'd2, 3'd0, 3'd0, 8'h00);
    checkOutput("b2b_all",    32'(bus2.OUT_ALL),   32'h0502);

    applyStimulus(3, 3'd1, 3'd3, 3'd0, 8'h33);
    checkOutput("n3_dst_err", 32'(bus3.err),       32'd1);
    checkOutput("n3_dst_upd", 32'(bus3.upd_valid), 32'd0);
    checkOutput("n3_dst_all", 32'(bus3.OUT_ALL),   32'h818181);
    applyStimulus(3, 3'd1, 3'd2, 3'd3, 8'h44);
    checkOutput("n3_ld2_all", 32'(bus3.OUT_ALL),   32'h448181);
    checkOutput("n3_ld2_upd", 32'(bus3.upd_valid), 32'd1);
    checkOutput("n3_sel3",    32'(bus3.OUT_SEL),   32'h00);
    applyStimulus(3, 3'd4, 3'd0, 3'd3, 8'h00);
    checkOutput("n3_src_err", 32'(bus3.err),       32'd1);
    checkOutput("n3_src_all", 32'(bus3.OUT_ALL),   32'h448181);

    reset_IDX = 1'b1;
    applyStimulus(2, 3'd1, 3'd1, 3'd0, 8'h33);
    checkOutput("rstld_all",  32'(bus2.OUT_ALL),   32'h0000);
    checkOutput("rstld_Z",    32'(bus2.flag_Z),    32'd1);
    checkOutput("rstld_upd",  32'(bus2.upd_valid), 32'd0);
    checkOutput("rstld3_all", 32'(bus3.OUT_ALL),   32'h818181);
    reset_IDX = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/index_register_bank.md
INDEX_REGISTER_BANK -- requirements
Module: index_register_bank

Interface
REQ-001 Parameter: WIDTH, default 8, register and data width in bits; legal range 2..32.
REQ-002 Parameter: NREG, default 2, number of index registers (reg0 = X, reg1 = Y); legal range 1..8.
REQ-003 Parameter: RESET_VAL, default 0, value loaded into every register on reset.
REQ-004 Derived: SW = max(1, clog2(NREG)) is the selector width.
REQ-005 Port: FSM_Signal, input, 1, the single clock; all state updates on its falling edge.
REQ-006 Port: reset_IDX, input, 1, synchronous active-high reset, sampled on the falling edge of FSM_Signal.
REQ-007 Port: op, input, 3, operation code: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 TRANSFER, 5 CLEAR, 6-7 illegal.
REQ-008 Port: sel_dst, input, SW, destination register index.
REQ-009 Port: sel_src, input, SW, source register index for TRANSFER and the read port.
REQ-010 Port: IN_DATA, input, WIDTH, load data.
REQ-011 Port: OUT_SEL, output, WIDTH, combinational read of reg[sel_src]; all zeros when sel_src >= NREG.
REQ-012 Port: OUT_ALL, output, NREG*WIDTH, registers concatenated, reg0 in the LSBs.
REQ-013 Port: flag_N, output, 1, MSB of the last written value (registered).
REQ-014 Port: flag_Z, output, 1, set when the last written value is zero (registered).
REQ-015 Port: flag_W, output, 1, set when the last INC or DEC wrapped (registered).
REQ-016 Port: upd_valid, output, 1, one-cycle pulse following every accepted write.
REQ-017 Port: err, output, 1, one-cycle pulse following a rejected operation.

Function
REQ-018 Ops are sampled once per falling edge; the result is visible on OUT_ALL, the flags, and upd_valid after that edge (latency 1).
REQ-019 LOAD: reg[sel_dst] <= IN_DATA.
REQ-020 INC: reg[sel_dst] <= reg[sel_dst] + 1 modulo 2^WIDTH; flag_W <= 1 when the old value is all ones, else 0.
REQ-021 DEC: reg[sel_dst] <= reg[sel_dst] - 1 modulo 2^WIDTH; flag_W <= 1 when the old value is zero, else 0.
REQ-022 TRANSFER: reg[sel_dst] <= reg[sel_src]; TRANSFER with sel_src == sel_dst is accepted and leaves the value unchanged.
REQ-023 CLEAR: reg[sel_dst] <= 0.
REQ-024 Accepted write (ops 1-5): flag_N and flag_Z are updated from the new value and upd_valid pulses.
REQ-025 flag_W is updated only by INC and DEC and is cleared by LOAD, TRANSFER and CLEAR.
REQ-026 NOP: no register, flag, upd_valid or err change; upd_valid and err return to 0.
REQ-027 Rejection (err pulses, nothing else changes, upd_valid stays 0) in any of these cases:
- illegal op (6 or 7);
- sel_dst >= NREG with any write op;
- sel_src >= NREG with TRANSFER.
REQ-028 Only one register is written per cycle; all non-selected registers hold.
REQ-029 Back-to-back ops on the same register chain without stalls; for example, INC on two consecutive edges yields +2.
REQ-030 upd_valid and err are never high in the same cycle.

Reset
REQ-031 When reset_IDX = 1 at an edge, all of the following take effect regardless of op:
- every register <= RESET_VAL;
- flag_N <= MSB of RESET_VAL;
- flag_Z <= (RESET_VAL == 0);
- flag_W <= 0;
- upd_valid <= 0;
- err <= 0.
REQ-032 Reset has priority over any op in the same cycle; that op is discarded.
REQ-033 Between power-up and the first reset edge, outputs are undefined; the bench applies reset before checking anything.

Verification
REQ-034 Directed scenarios (WIDTH=8, NREG=2 unless noted):
- reset, then LOAD reg1 = 8'h7F, then INC reg1 -> reg1 = 8'h80, flag_N = 1, flag_Z = 0, flag_W = 0, upd_valid pulses once per op.
- LOAD reg0 = 8'hFF, then INC reg0 -> reg0 = 8'h00, flag_Z = 1, flag_W = 1; then DEC reg0 -> reg0 = 8'hFF, flag_W = 1, flag_N = 1.
- LOAD reg0 = 8'h05, then TRANSFER src 0 -> dst 1 -> reg1 = 8'h05, reg0 unchanged, flag_W = 0.
- op = 6 / 7 -> err pulses for one cycle, all registers and flags unchanged, upd_valid = 0.
- NREG=3, sel_dst = 3 with LOAD -> err pulses, no register written.
- LOAD reg1 = 8'h33 issued in the same cycle as reset_IDX = 1 -> all registers = RESET_VAL, flag_Z = 1, upd_valid = 0.
